instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Two-byte instruction sequencer: fetches opcode+operand, optionally reads/writes data memory,
// strobes the ALU, and handles relative jumps plus a bounded return-address stack.
module instr_sequencer #(
    parameter int INST_ADDR_WIDTH = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int MEM_ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH     = 4,
    parameter int RESET_PC        = 0
) (
    input  logic                       clk,
    input  logic                       arst,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr,
    output logic                       inst_req,
    input  logic                       inst_ack,
    input  logic [DATA_WIDTH-1:0]      inst_data,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
    output logic                       mem_req,
    output logic                       mem_we,
    input  logic                       mem_ack,
    input  logic [DATA_WIDTH-1:0]      mem_data_i,
    output logic [DATA_WIDTH-1:0]      mem_data_o,
    output logic                       exec,
    input  logic [3:0]                 Flags,
    input  logic [DATA_WIDTH-1:0]      AR,
    output logic [DATA_WIDTH-1:0]      IR,
    output logic [DATA_WIDTH-1:0]      IBR,
    output logic [DATA_WIDTH-1:0]      MBR,
    output logic                       halted,
    output logic                       stack_err
);

    typedef logic [DATA_WIDTH-1:0] word_t;

    // Flag bit positions and opcode encodings shared with the ALU definitions.
    localparam int F_ZERO  = 0;
    localparam int F_CARRY = 1;
    localparam int F_NEG   = 2;
    localparam int F_OV    = 3;

    localparam word_t OP_LOAD_X  = word_t'(8'h01);
    localparam word_t OP_JMP     = word_t'(8'hC0);
    localparam word_t OP_JZ      = word_t'(8'hC1);
    localparam word_t OP_JC      = word_t'(8'hC2);
    localparam word_t OP_JN      = word_t'(8'hC3);
    localparam word_t OP_JV      = word_t'(8'hC4);
    localparam word_t OP_CALL    = word_t'(8'hC8);
    localparam word_t OP_RET     = word_t'(8'hC9);
    localparam word_t OP_STORE_X = word_t'(8'hD0);
    localparam word_t OP_STORE_I = word_t'(8'hD1);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {F_OP, F_ARG, DECODE, MEM_RD, EXEC, MEM_WR} state_t;

    state_t                     state;
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic [INST_ADDR_WIDTH-1:0] op_addr;
    logic [INST_ADDR_WIDTH-1:0] stack [STACK_DEPTH];
    logic [SPW-1:0]             sp;

    logic                       is_jump, is_call, is_ret, is_store, exec_op, needs_rd, taken;
    logic                       stack_full, stack_empty;
    logic signed [DATA_WIDTH-1:0] ibr_s;
    logic [INST_ADDR_WIDTH-1:0] target;
    logic [SIW-1:0]             push_idx, pop_idx;

    assign inst_addr = pc;

    assign is_jump  = (IR == OP_JMP) || (IR == OP_JZ) || (IR == OP_JC) ||
                      (IR == OP_JN)  || (IR == OP_JV);
    assign is_call  = (IR == OP_CALL);
    assign is_ret   = (IR == OP_RET);
    assign is_store = (IR == OP_STORE_X) || (IR == OP_STORE_I);
    assign exec_op  = !(is_jump || is_call || is_ret || is_store);
    assign needs_rd = (IR == OP_LOAD_X) ||
                      (((IR[7:6] == 2'b01) || (IR[7:6] == 2'b10)) && (IR[5:2] == 4'b0000));

    always_comb begin
        taken = 1'b0;
        case (IR)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = Flags[F_ZERO];
            OP_JC:   taken = Flags[F_CARRY];
            OP_JN:   taken = Flags[F_NEG];
            OP_JV:   taken = Flags[F_OV];
            default: taken = 1'b0;
        endcase
    end

    // Branch offset is relative to the opcode byte, sign-extended (or truncated) to PC width.
    assign ibr_s       = IBR;
    assign target      = op_addr + INST_ADDR_WIDTH'(ibr_s);
    assign stack_full  = (sp == SPW'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign push_idx    = SIW'(sp);
    assign pop_idx     = SIW'(sp - SPW'(1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= F_OP;
            pc         <= INST_ADDR_WIDTH'(RESET_PC);
            op_addr    <= '0;
            sp         <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
            inst_req   <= 1'b0;
            mem_addr   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_data_o <= '0;
            exec       <= 1'b0;
            IR         <= '0;
            IBR        <= '0;
            MBR        <= '0;
            halted     <= 1'b0;
            stack_err  <= 1'b0;
        end else begin
            exec <= 1'b0;
            case (state)
                F_OP: begin
                    // Request is raised one cycle late only when leaving reset.
                    if (!halted) begin
                        if (!inst_req) begin
                            inst_req <= 1'b1;
                        end else if (inst_ack) begin
                            IR      <= inst_data;
                            op_addr <= pc;
                            pc      <= pc + 1'b1;
                            state   <= F_ARG;
                        end
                    end
                end
                F_ARG: begin
                    if (inst_ack) begin
                        IBR      <= inst_data;
                        pc       <= pc + 1'b1;
                        inst_req <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    if (needs_rd) begin
                        mem_addr <= MEM_ADDR_WIDTH'(IBR);
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        state    <= MEM_RD;
                    end else begin
                        exec  <= exec_op;
                        state <= EXEC;
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        MBR     <= mem_data_i;
                        mem_req <= 1'b0;
                        exec    <= exec_op;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    state    <= F_OP;
                    inst_req <= 1'b1;
                    if (is_call) begin
                        if (stack_full) begin
                            stack_err <= 1'b1;
                            halted    <= 1'b1;
                            inst_req  <= 1'b0;
                        end else begin
                            stack[push_idx] <= pc;
                            sp              <= sp + 1'b1;
                            pc              <= target;
                        end
                    end else if (is_ret) begin
                        if (stack_empty) begin
                            stack_err <= 1'b1;
                            halted    <= 1'b1;
                            inst_req  <= 1'b0;
                        end else begin
                            pc <= stack[pop_idx];
                            sp <= sp - 1'b1;
                        end
                    end else if (is_jump) begin
                        if (taken) pc <= target;
                    end else if (is_store) begin
                        inst_req <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        state    <= MEM_WR;
                        if (IR == OP_STORE_X) begin
                            mem_addr   <= MEM_ADDR_WIDTH'(IBR);
                            mem_data_o <= AR;
                        end else begin
                            mem_addr   <= MEM_ADDR_WIDTH'(AR);
                            mem_data_o <= IBR;
                        end
                    end
                end
                MEM_WR: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        inst_req <= 1'b1;
                        state    <= F_OP;
                    end
                end
                default: begin
                    state <= F_OP;
                end
            endcase
        end
    end

endmodule
